// File: rtl/mem_resp_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_resp_demux_pkg
// Purpose : Shared owner encodings and helper types for the memory response
//           demultiplexer. The 2:1 request mux uses the same port encodings,
//           so a tag stored here can be compared directly against its SELECT.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mem_resp_demux_pkg;

  // Owner encodings, identical to the request mux SELECT values.
  localparam logic PORT_IF   = 1'b0;  // instruction fetch
  localparam logic PORT_DATA = 1'b1;  // data access

  // One owner tag as stored in the tag FIFO.
  typedef logic owner_t;

  // Action applied to an outstanding counter in one cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

  // Encode increment/decrement strobes as a counter action.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    return cnt_op_e'({inc, dec});
  endfunction

endpackage : mem_resp_demux_pkg
`default_nettype wire

// File: rtl/mem_resp_demux_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tag_fifo
// Purpose : 1-bit-wide owner-tag FIFO with DEPTH entries. Records the owner of
//           every issued memory transaction in issue order.
// Ports   : clk_i    clock, rising edge
//           rst_ni   asynchronous active-low reset (empties the FIFO)
//           push_i   store tag_i at the tail (ignored when full)
//           tag_i    owner tag to store
//           pop_i    remove the head entry (ignored when empty)
//           full_o   occupancy == DEPTH (registered occupancy only)
//           empty_o  occupancy == 0
//           head_o   tag at the head of the FIFO
// Rev     : 1.0  initial release
// ============================================================================
module tag_fifo
  import mem_resp_demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  owner_t tag_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full is judged on the registered occupancy, so a push into a full FIFO is
  // dropped even if a pop frees an entry in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = tag_i;
      // DEPTH is a power of two, so the natural pointer rollover is the wrap.
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case (cnt_op(push_ok, pop_ok))
      CNT_INC: count_d = count_q + CNT_W'(1);
      CNT_DEC: count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : tag_fifo
`default_nettype wire

// File: rtl/mem_resp_demux.sv
`default_nettype none
// ============================================================================
// Module  : mem_resp_demux
// Purpose : Response-side counterpart of the 2:1 memory request mux. Records
//           the owner of each issued transaction and routes every returning
//           response back to that owner in issue order, with per-port BUSY
//           stalls and a sticky unexpected-response error.
// Ports   : CLK             clock, rising edge
//           RESET_N         asynchronous active-low reset
//           REQ_VALID       upstream issues a request this cycle
//           REQ_SELECT      owner of that request (0=fetch, 1=data)
//           REQ_READY       tag FIFO not full
//           MEM_RESP_VALID  memory returns one response this cycle
//           MEM_RESP_DATA   response data
//           RESP0_VALID/DATA  port-0 pulse and held data
//           RESP1_VALID/DATA  port-1 pulse and held data
//           BUSY0/BUSY1     port has at least one outstanding transaction
//           ERR_UNEXPECTED  sticky: response with no outstanding tag
// Rev     : 1.0  initial release
// ============================================================================
module mem_resp_demux
  import mem_resp_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_VALID,
  input  logic                  REQ_SELECT,
  output logic                  REQ_READY,
  input  logic                  MEM_RESP_VALID,
  input  logic [DATA_WIDTH-1:0] MEM_RESP_DATA,
  output logic                  RESP0_VALID,
  output logic [DATA_WIDTH-1:0] RESP0_DATA,
  output logic                  RESP1_VALID,
  output logic [DATA_WIDTH-1:0] RESP1_DATA,
  output logic                  BUSY0,
  output logic                  BUSY1,
  output logic                  ERR_UNEXPECTED
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic   fifo_full;
  logic   fifo_empty;
  owner_t head_tag;

  logic push;
  logic pop;

  logic [CNT_W-1:0]      cnt0_q, cnt0_d;
  logic [CNT_W-1:0]      cnt1_q, cnt1_d;
  logic                  resp0_valid_q, resp0_valid_d;
  logic                  resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0] resp0_data_q, resp0_data_d;
  logic [DATA_WIDTH-1:0] resp1_data_q, resp1_data_d;
  logic                  err_q, err_d;

  // Ready is forced low while reset is asserted so every output reads 0 then.
  assign REQ_READY = RESET_N & ~fifo_full;
  assign push      = REQ_VALID & REQ_READY;
  // A response is matched only against tags already stored; a same-cycle
  // request is not yet visible at the head.
  assign pop       = MEM_RESP_VALID & ~fifo_empty;

  tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .push_i  (push),
    .tag_i   (REQ_SELECT),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_tag)
  );

  always_comb begin
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_data_d  = resp0_data_q;
    resp1_data_d  = resp1_data_q;
    err_d         = err_q | (MEM_RESP_VALID & fifo_empty);

    // Push and pop for the same port cancel out.
    case (cnt_op(push & (REQ_SELECT == PORT_IF), pop & (head_tag == PORT_IF)))
      CNT_INC: cnt0_d = cnt0_q + CNT_W'(1);
      CNT_DEC: cnt0_d = cnt0_q - CNT_W'(1);
      default: cnt0_d = cnt0_q;
    endcase
    case (cnt_op(push & (REQ_SELECT == PORT_DATA), pop & (head_tag == PORT_DATA)))
      CNT_INC: cnt1_d = cnt1_q + CNT_W'(1);
      CNT_DEC: cnt1_d = cnt1_q - CNT_W'(1);
      default: cnt1_d = cnt1_q;
    endcase

    if (pop) begin
      if (head_tag == PORT_IF) begin
        resp0_valid_d = 1'b1;
        resp0_data_d  = MEM_RESP_DATA;
      end else begin
        resp1_valid_d = 1'b1;
        resp1_data_d  = MEM_RESP_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
      err_q         <= err_d;
    end
  end

  assign RESP0_VALID    = resp0_valid_q;
  assign RESP0_DATA     = resp0_data_q;
  assign RESP1_VALID    = resp1_valid_q;
  assign RESP1_DATA     = resp1_data_q;
  assign BUSY0          = (cnt0_q != '0);
  assign BUSY1          = (cnt1_q != '0);
  assign ERR_UNEXPECTED = err_q;

endmodule : mem_resp_demux
`default_nettype wire

// File: tb/tb_mem_resp_demux.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_resp_demux
// Purpose : Directed self-checking bench for mem_resp_demux. Expected routed
//           responses go into a scoreboard queue when a memory response is
//           driven; a negedge monitor pops and compares every RESP pulse.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_resp_demux;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_SELECT = 1'b0;
  logic          REQ_READY;
  logic          MEM_RESP_VALID = 1'b0;
  logic [DW-1:0] MEM_RESP_DATA = '0;
  logic          RESP0_VALID;
  logic [DW-1:0] RESP0_DATA;
  logic          RESP1_VALID;
  logic [DW-1:0] RESP1_DATA;
  logic          BUSY0;
  logic          BUSY1;
  logic          ERR_UNEXPECTED;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] held0 = '0;
  logic [DW-1:0] held1 = '0;

  always #5 CLK = ~CLK;

  mem_resp_demux #(
    .DATA_WIDTH (DW),
    .DEPTH      (2)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .REQ_VALID      (REQ_VALID),
    .REQ_SELECT     (REQ_SELECT),
    .REQ_READY      (REQ_READY),
    .MEM_RESP_VALID (MEM_RESP_VALID),
    .MEM_RESP_DATA  (MEM_RESP_DATA),
    .RESP0_VALID    (RESP0_VALID),
    .RESP0_DATA     (RESP0_DATA),
    .RESP1_VALID    (RESP1_VALID),
    .RESP1_DATA     (RESP1_DATA),
    .BUSY0          (BUSY0),
    .BUSY1          (BUSY1),
    .ERR_UNEXPECTED (ERR_UNEXPECTED)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive a memory response and record which port must receive it.
  task automatic resp(input logic [DW-1:0] data, input logic owner);
    exp_t e;
    MEM_RESP_VALID = 1'b1;
    MEM_RESP_DATA  = data;
    e.port = owner;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    REQ_VALID      = 1'b0;
    MEM_RESP_VALID = 1'b0;
  endtask

  // Monitor: every RESP pulse must match the oldest scoreboard entry, and
  // the other port's data must hold its last routed value.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET_N) begin
      held0 = '0;
      held1 = '0;
    end else if (RESP0_VALID || RESP1_VALID) begin
      if (RESP0_VALID && RESP1_VALID) begin
        chk("both_valid", 32'd1, 32'd0);
      end else if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {31'd0, RESP1_VALID}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("mon_port", {31'd0, RESP1_VALID}, {31'd0, e.port});
        if (e.port) held1 = e.data;
        else        held0 = e.data;
        chk("mon_data0", RESP0_DATA, held0);
        chk("mon_data1", RESP1_DATA, held1);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       tags[4];
    logic       owners[4];
    logic [DW-1:0] datas[4];
    tags   = '{1'b1, 1'b1, 1'b0, 1'b1};
    owners = '{1'b0, 1'b1, 1'b1, 1'b0};
    datas  = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};

    // ---- 1: reset, then reset mid-transfer ----
    tick(); tick();
    chk("rst_ready", {31'd0, REQ_READY}, 32'd0);
    chk("rst_busy0", {31'd0, BUSY0}, 32'd0);
    RESET_N = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, REQ_READY}, 32'd1);
    chk("post_rst_busy1", {31'd0, BUSY1}, 32'd0);
    chk("post_rst_err", {31'd0, ERR_UNEXPECTED}, 32'd0);
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    REQ_VALID = 1'b1; REQ_SELECT = 1'b1; tick();
    idle();
    chk("full_ready", {31'd0, REQ_READY}, 32'd0);
    chk("full_busy1", {31'd0, BUSY1}, 32'd1);
    resp(32'hAAAA_5555, 1'b0); tick();
    idle();
    chk("pre_rst_data0", RESP0_DATA, 32'hAAAA_5555);
    tick();
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_data0", RESP0_DATA, 32'd0);
    chk("mid_rst_busy1", {31'd0, BUSY1}, 32'd0);
    chk("mid_rst_ready", {31'd0, REQ_READY}, 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    chk("rel_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rel_busy1", {31'd0, BUSY1}, 32'd0);

    // ---- 2: single port-0 transaction ----
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    idle();
    chk("t2_busy0", {31'd0, BUSY0}, 32'd1);
    chk("t2_busy1", {31'd0, BUSY1}, 32'd0);
    tick();
    chk("t2_busy0_hold", {31'd0, BUSY0}, 32'd1);
    resp(32'hDEAD_BEEF, 1'b0); tick();
    idle();
    chk("t2_r0v", {31'd0, RESP0_VALID}, 32'd1);
    chk("t2_r0d", RESP0_DATA, 32'hDEAD_BEEF);
    chk("t2_r1v", {31'd0, RESP1_VALID}, 32'd0);
    chk("t2_r1d", RESP1_DATA, 32'd0);
    chk("t2_busy0_clr", {31'd0, BUSY0}, 32'd0);
    tick();
    chk("t2_r0v_pulse", {31'd0, RESP0_VALID}, 32'd0);
    chk("t2_r0d_held", RESP0_DATA, 32'hDEAD_BEEF);

    // ---- 3: in-order routing across ports ----
    REQ_VALID = 1'b1; REQ_SELECT = 1'b1; tick();
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    idle();
    chk("t3_ready_full", {31'd0, REQ_READY}, 32'd0);
    resp(32'h0000_0011, 1'b1); tick();
    chk("t3_r1d", RESP1_DATA, 32'h0000_0011);
    chk("t3_r0d_held", RESP0_DATA, 32'hDEAD_BEEF);
    chk("t3_ready", {31'd0, REQ_READY}, 32'd1);
    resp(32'h0000_0022, 1'b0); tick();
    idle();
    chk("t3_r0d", RESP0_DATA, 32'h0000_0022);
    chk("t3_busy0", {31'd0, BUSY0}, 32'd0);

    // ---- 4: full + simultaneous pop drops the push; wrap traffic ----
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    REQ_VALID = 1'b1; REQ_SELECT = 1'b1; tick();
    REQ_VALID = 1'b1; REQ_SELECT = 1'b1;
    resp(32'h0000_0033, 1'b0); tick();
    idle();
    chk("t4_ready", {31'd0, REQ_READY}, 32'd1);
    chk("t4_busy0", {31'd0, BUSY0}, 32'd0);
    resp(32'h0000_0044, 1'b1); tick();
    idle();
    chk("t4_dropped_busy1", {31'd0, BUSY1}, 32'd0);
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      REQ_VALID = 1'b1; REQ_SELECT = tags[i];
      resp(datas[i], owners[i]);
      tick();
      chk("t4_wrap_ready", {31'd0, REQ_READY}, 32'd1);
    end
    idle();
    chk("t4_wrap_busy1", {31'd0, BUSY1}, 32'd1);
    chk("t4_wrap_busy0", {31'd0, BUSY0}, 32'd0);
    resp(32'h0000_005A, 1'b1); tick();
    idle();
    chk("t4_drain_busy1", {31'd0, BUSY1}, 32'd0);

    // ---- 6: same-port push and pop in one cycle ----
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0;
    resp(32'h0000_0066, 1'b0); tick();
    idle();
    chk("t6_busy0", {31'd0, BUSY0}, 32'd1);
    resp(32'h0000_0077, 1'b0); tick();
    idle();
    chk("t6_busy0_clr", {31'd0, BUSY0}, 32'd0);
    chk("t6_err", {31'd0, ERR_UNEXPECTED}, 32'd0);

    // ---- 5: response with empty FIFO; sticky error; late response ----
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0000_0099;
    REQ_VALID = 1'b1; REQ_SELECT = 1'b1; tick();
    idle();
    chk("t5_err", {31'd0, ERR_UNEXPECTED}, 32'd1);
    chk("t5_r0v", {31'd0, RESP0_VALID}, 32'd0);
    chk("t5_r1v", {31'd0, RESP1_VALID}, 32'd0);
    chk("t5_push_busy1", {31'd0, BUSY1}, 32'd1);
    tick();
    chk("t5_err_sticky", {31'd0, ERR_UNEXPECTED}, 32'd1);
    resp(32'h0000_00AB, 1'b1); tick();
    idle();
    chk("t5_err_sticky2", {31'd0, ERR_UNEXPECTED}, 32'd1);
    REQ_VALID = 1'b1; REQ_SELECT = 1'b0; tick();
    idle();
    #2 RESET_N = 1'b0;
    #1;
    chk("t5_rst_err", {31'd0, ERR_UNEXPECTED}, 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0000_0BAD; tick();
    idle();
    chk("t5_late_err", {31'd0, ERR_UNEXPECTED}, 32'd1);
    chk("t5_late_r0v", {31'd0, RESP0_VALID}, 32'd0);

    tick(); tick();
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_resp_demux
`default_nettype wire
